// File: rtl/mem_pkg.sv
// Shared definitions for the cache / main-memory interface: widths, responder
// state encoding and the read/write direction constants.
package mem_pkg;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 20;

  // Wide enough for the largest legal latency (15).
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } mem_state_t;

  localparam logic MEM_READ  = 1'b0;
  localparam logic MEM_WRITE = 1'b1;

endpackage : mem_pkg

// File: rtl/mem_sram_array.sv
// Word-addressed storage behind the memory responder: synchronous write,
// combinational read, whole array cleared while rst_n is low.
module mem_sram_array #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];

  // The reset clear must reach every word, so the array lives in fabric
  // registers rather than a RAM primitive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (we) begin
      r_mem[addr] <= wdata;
    end
  end

  assign rdata = r_mem[addr];

endmodule : mem_sram_array

// File: rtl/mem_responder.sv
// Main-memory responder: fixed-latency single-word read / write-back with a
// one-cycle mem_ready pulse. Optional request counters under MEM_RESP_STATS_EN.
module mem_responder #(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 20,
  parameter int LATENCY = 4   // legal range 1..15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_req,
  input  logic              mem_rw,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data_in,
  output logic [DATA_W-1:0] mem_data_out,
  output logic              mem_ready,
  output logic              mem_busy
`ifdef MEM_RESP_STATS_EN
  ,
  output logic [15:0]       rd_count,
  output logic [15:0]       wr_count
`endif
);

  import mem_pkg::*;

  mem_state_t        r_state;
  mem_state_t        w_state_next;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_rw;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_data_out;
  logic [DATA_W-1:0] w_rdata;
  logic              w_accept;
  logic              w_access;
  logic              w_we;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_access     = 1'b0;
    mem_busy     = 1'b0;
    mem_ready    = 1'b0;
    case (r_state)
      IDLE: begin
        if (mem_req) begin
          w_accept     = 1'b1;
          w_state_next = WAIT;
        end
      end
      WAIT: begin
        mem_busy = 1'b1;
        if (r_cnt == '0) begin
          w_access     = 1'b1;
          w_state_next = RESP;
        end
      end
      RESP: begin
        mem_busy     = 1'b1;
        mem_ready    = 1'b1;
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Request fields are captured only on acceptance, so the requester may
  // change its bus freely while the access is in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_rw    <= MEM_READ;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_accept) begin
      r_cnt   <= CNT_W'(LATENCY - 1);
      r_rw    <= mem_rw;
      r_addr  <= mem_addr;
      r_wdata <= mem_data_in;
    end else if (r_state == WAIT && r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign w_we = w_access && (r_rw == MEM_WRITE);

  mem_sram_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_array (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (w_we),
    .addr  (r_addr),
    .wdata (r_wdata),
    .rdata (w_rdata)
  );

  // Read data is registered on the RESP entry edge and held until the next read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data_out <= '0;
    end else if (w_access && r_rw == MEM_READ) begin
      r_data_out <= w_rdata;
    end
  end

  assign mem_data_out = r_data_out;

`ifdef MEM_RESP_STATS_EN
  logic [15:0] r_rd_count;
  logic [15:0] r_wr_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_count <= '0;
      r_wr_count <= '0;
    end else if (w_access) begin
      if (r_rw == MEM_READ && r_rd_count != 16'hFFFF) begin
        r_rd_count <= r_rd_count + 16'd1;
      end
      if (r_rw == MEM_WRITE && r_wr_count != 16'hFFFF) begin
        r_wr_count <= r_wr_count + 16'd1;
      end
    end
  end

  assign rd_count = r_rd_count;
  assign wr_count = r_wr_count;
`endif

`ifndef SYNTHESIS
  a_rw_known: assert property (@(posedge clk) disable iff (!rst_n)
    (r_state == IDLE && mem_req) |-> !$isunknown(mem_rw));
`endif

endmodule : mem_responder
